// File: rtl/wb_register_file_pkg.sv
// Shared widths and write-back control decoding for the write-back stage and register file.
package wb_register_file_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_register_file_register_file.sv
// Architectural register file: register 0 hardwired to zero, one write port,
// two combinational read ports with same-cycle write-through bypass.
module register_file #(
    parameter int unsigned DATA_WIDTH     = wb_register_file_pkg::DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = wb_register_file_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      write_enable,
    input  logic                      bypass_enable,
    input  logic [REG_ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;

    // No storage exists for register 0; callers only enable writes to nonzero addresses.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[write_addr] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = '0;
        if (read_addr_1 != '0) begin
            if (bypass_enable && (read_addr_1 == write_addr)) begin
                read_data_1 = write_data;
            end else begin
                read_data_1 = regs[read_addr_1];
            end
        end
    end

    always_comb begin
        read_data_2 = '0;
        if (read_addr_2 != '0) begin
            if (bypass_enable && (read_addr_2 == write_addr)) begin
                read_data_2 = write_data;
            end else begin
                read_data_2 = regs[read_addr_2];
            end
        end
    end

endmodule

// File: rtl/wb_register_file.sv
// Write-back stage: selects memory or ALU result, qualifies the write strobe,
// commits to the register file and counts retired writes.
module wb_register_file #(
    parameter int unsigned DATA_WIDTH     = wb_register_file_pkg::DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = wb_register_file_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     read_data_input,
    input  logic [DATA_WIDTH-1:0]     alu_result_input,
    input  logic [REG_ADDR_WIDTH-1:0] write_register_input,
    input  logic [1:0]                WB_input,
    input  logic [REG_ADDR_WIDTH-1:0] read_register_1_input,
    input  logic [REG_ADDR_WIDTH-1:0] read_register_2_input,
    output logic [DATA_WIDTH-1:0]     read_data_1_output,
    output logic [DATA_WIDTH-1:0]     read_data_2_output,
    output logic [DATA_WIDTH-1:0]     write_data_output,
    output logic                      write_enable_output,
    output logic [31:0]               write_count_output
);

    import wb_register_file_pkg::*;

    wb_src_e               wb_src;
    logic                  write_request;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic [31:0]           write_count;

    assign wb_src     = wb_src_e'(WB_input[WB_MEMTOREG]);
    assign write_data = (wb_src == WB_SRC_MEM) ? read_data_input : alu_result_input;

    // Flops ignore D while reset is low, so only the visible strobe and bypass need reset_n.
    assign write_request = WB_input[WB_REGWRITE] && (write_register_input != '0);
    assign write_enable  = reset_n && write_request;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_count <= '0;
        end else if (write_request) begin
            write_count <= write_count + 32'd1;
        end
    end

    register_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_register_file (
        .clock         (clock),
        .reset_n       (reset_n),
        .write_enable  (write_request),
        .bypass_enable (write_enable),
        .write_addr    (write_register_input),
        .write_data    (write_data),
        .read_addr_1   (read_register_1_input),
        .read_addr_2   (read_register_2_input),
        .read_data_1   (read_data_1_output),
        .read_data_2   (read_data_2_output)
    );

    assign write_data_output   = write_data;
    assign write_enable_output = write_enable;
    assign write_count_output  = write_count;

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: array-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_wb_register_file;

    logic        clock;
    logic        reset_n;
    logic [31:0] read_data_input;
    logic [31:0] alu_result_input;
    logic [4:0]  write_register_input;
    logic [1:0]  WB_input;
    logic [4:0]  read_register_1_input;
    logic [4:0]  read_register_2_input;
    logic [31:0] read_data_1_output;
    logic [31:0] read_data_2_output;
    logic [31:0] write_data_output;
    logic        write_enable_output;
    logic [31:0] write_count_output;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    wb_register_file #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .read_data_input       (read_data_input),
        .alu_result_input      (alu_result_input),
        .write_register_input  (write_register_input),
        .WB_input              (WB_input),
        .read_register_1_input (read_register_1_input),
        .read_register_2_input (read_register_2_input),
        .read_data_1_output    (read_data_1_output),
        .read_data_2_output    (read_data_2_output),
        .write_data_output     (write_data_output),
        .write_enable_output   (write_enable_output),
        .write_count_output    (write_count_output)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wdata();
        return WB_input[0] ? read_data_input : alu_result_input;
    endfunction

    function automatic logic exp_we();
        return reset_n && WB_input[1] && (write_register_input != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (exp_we() && addr == write_register_input) return exp_wdata();
        return model_regs[addr];
    endfunction

    // Reference model: a plain array and a counter updated from the architectural rules.
    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
            model_count <= 32'd0;
        end else if (exp_we()) begin
            model_regs[write_register_input] <= exp_wdata();
            model_count <= model_count + 32'd1;
        end
    end

    always @(negedge clock) begin
        check("model_wdata", write_data_output, exp_wdata());
        check("model_we", {31'd0, write_enable_output}, {31'd0, exp_we()});
        check("model_rd1", read_data_1_output, exp_read(read_register_1_input));
        check("model_rd2", read_data_2_output, exp_read(read_register_2_input));
        check("model_count", write_count_output, model_count);
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] r1, input logic [4:0] r2);
        WB_input              = wb;
        write_register_input  = wr;
        alu_result_input      = alu;
        read_data_input       = mem;
        read_register_1_input = r1;
        read_register_2_input = r2;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(2'b10, 5'd5, 32'hCAFEF00D, 32'h0, 5'd5, 5'd0);
        #1;
        check("rst_rd1", read_data_1_output, 32'h0);
        check("rst_rd2", read_data_2_output, 32'h0);
        check("rst_wdata", write_data_output, 32'hCAFEF00D);
        check("rst_we", {31'd0, write_enable_output}, 32'd0);
        check("rst_count", write_count_output, 32'h0);
        step();
        step();
        check("rst_hold_rd1", read_data_1_output, 32'h0);
        check("rst_hold_count", write_count_output, 32'h0);

        drive(2'b00, 5'd5, 32'h0, 32'h0, 5'd5, 5'd0);
        reset_n = 1'b1;

        // ALU write-back to r31 with same-cycle bypass
        drive(2'b10, 5'h1F, 32'h5A5A5A5A, 32'hA5A5A5A5, 5'h1F, 5'd0);
        #1;
        check("alu_bypass_rd1", read_data_1_output, 32'h5A5A5A5A);
        check("alu_wdata", write_data_output, 32'h5A5A5A5A);
        check("alu_we", {31'd0, write_enable_output}, 32'd1);
        check("alu_rd2_zero", read_data_2_output, 32'h0);
        step();
        drive(2'b00, 5'h1F, 32'h0, 32'h0, 5'h1F, 5'h1F);
        #1;
        check("alu_stored_rd1", read_data_1_output, 32'h5A5A5A5A);
        check("alu_stored_rd2", read_data_2_output, 32'h5A5A5A5A);
        check("alu_count", write_count_output, 32'd1);

        // Load write-back to r10
        drive(2'b11, 5'h0A, 32'h0, 32'hFFFFFFFF, 5'h0A, 5'h1F);
        #1;
        check("load_wdata", write_data_output, 32'hFFFFFFFF);
        check("load_bypass", read_data_1_output, 32'hFFFFFFFF);
        step();
        drive(2'b00, 5'h0A, 32'h0, 32'h0, 5'h0A, 5'h0A);
        #1;
        check("load_stored", read_data_1_output, 32'hFFFFFFFF);
        check("load_count", write_count_output, 32'd2);

        // Bubble to r15, then RegWrite to r0
        drive(2'b01, 5'h0F, 32'h13572468, 32'h24681357, 5'h0F, 5'h0A);
        #1;
        check("bubble_wdata", write_data_output, 32'h24681357);
        check("bubble_we", {31'd0, write_enable_output}, 32'd0);
        check("bubble_rd1", read_data_1_output, 32'h0);
        step();
        drive(2'b10, 5'h00, 32'h12345678, 32'h0, 5'h00, 5'h0F);
        #1;
        check("r0_we", {31'd0, write_enable_output}, 32'd0);
        check("r0_rd1", read_data_1_output, 32'h0);
        check("r0_wdata", write_data_output, 32'h12345678);
        step();
        drive(2'b00, 5'h00, 32'h0, 32'h0, 5'h00, 5'h0F);
        #1;
        check("r0_after_rd1", read_data_1_output, 32'h0);
        check("r15_after_rd2", read_data_2_output, 32'h0);
        check("zero_count", write_count_output, 32'd2);

        // Dual bypass, then back-to-back write to the same register
        drive(2'b10, 5'h0A, 32'h87654321, 32'h0, 5'h0A, 5'h0A);
        #1;
        check("dual_rd1", read_data_1_output, 32'h87654321);
        check("dual_rd2", read_data_2_output, 32'h87654321);
        step();
        drive(2'b10, 5'h0A, 32'h11111111, 32'h0, 5'h0A, 5'h0A);
        #1;
        check("b2b_bypass", read_data_1_output, 32'h11111111);
        check("b2b_count_mid", write_count_output, 32'd3);
        step();
        drive(2'b00, 5'h0A, 32'h0, 32'h0, 5'h0A, 5'h1F);
        #1;
        check("b2b_last_wins", read_data_1_output, 32'h11111111);
        check("b2b_r31_kept", read_data_2_output, 32'h5A5A5A5A);
        check("b2b_count", write_count_output, 32'd4);

        for (int i = 1; i <= 5; i++) begin
            drive(2'b10, 5'(i), 32'(i) * 32'h01010101, 32'h0, 5'(i), 5'd0);
            step();
        end
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        check("loop_count", write_count_output, 32'd9);
        for (int i = 1; i <= 5; i++) begin
            read_register_1_input = 5'(i);
            read_register_2_input = 5'(6 - i);
            #1;
            check("loop_rd1", read_data_1_output, 32'(i) * 32'h01010101);
            check("loop_rd2", read_data_2_output, 32'(6 - i) * 32'h01010101);
        end

        // Asynchronous reset pulse between edges
        step();
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'h0A, 5'h1F);
        reset_n = 1'b0;
        #1;
        check("pulse_rd1", read_data_1_output, 32'h0);
        check("pulse_rd2", read_data_2_output, 32'h0);
        check("pulse_count", write_count_output, 32'h0);
        reset_n = 1'b1;
        drive(2'b10, 5'h03, 32'hDEADBEEF, 32'h0, 5'h03, 5'h0A);
        #1;
        check("post_bypass", read_data_1_output, 32'hDEADBEEF);
        check("post_r10_cleared", read_data_2_output, 32'h0);
        step();
        drive(2'b00, 5'h03, 32'h0, 32'h0, 5'h03, 5'h01);
        #1;
        check("post_stored", read_data_1_output, 32'hDEADBEEF);
        check("post_r1_cleared", read_data_2_output, 32'h0);
        check("post_count", write_count_output, 32'd1);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_register_file.md
# wb_register_file

Write-back stage and architectural register file for the 5-stage pipeline. Consumes the MEM_WB pipeline register outputs, selects the write-back value (memory data or ALU result), commits it to a 32 x 32-bit register file, and serves the two ID-stage read ports with same-cycle write-through bypass. Also exports the selected write-back value for the forwarding unit and a retired-write counter for debug.

## Interface
- DATA_WIDTH, 32, register and datapath width
- REG_ADDR_WIDTH, 5, register index width (2^5 registers)
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- read_data_input  input  32  memory load data from MEM_WB read_data_output
- alu_result_input  input  32  ALU result from MEM_WB alu_result_output
- write_register_input  input  5  destination register from MEM_WB write_register_output
- WB_input  input  2  control from MEM_WB WB_output; bit 1 = RegWrite, bit 0 = MemtoReg
- read_register_1_input  input  5  ID-stage source register rs
- read_register_2_input  input  5  ID-stage source register rt
- read_data_1_output  output  32  value of rs
- read_data_2_output  output  32  value of rt
- write_data_output  output  32  selected write-back value (to forwarding unit)
- write_enable_output  output  1  effective write strobe this cycle
- write_count_output  output  32  number of committed writes since reset

## Operation
- Write-back mux: write_data = WB_input[0] ? read_data_input : alu_result_input. Combinational, always driven regardless of RegWrite.
- Effective write: we = reset_n & WB_input[1] & (write_register_input != 0). write_enable_output = we.
- Commit: on rising clock edge with we = 1, reg[write_register_input] <= write_data.
- Register 0: hardwired zero; writes to it are dropped, not counted, and never bypassed.
- Reads: combinational. If we = 1 and read address equals write_register_input, output write_data (write-through bypass); else output reg[addr]. Address 0 always reads 0.
- Both read ports independent; both may hit the bypass in the same cycle.
- Counter: increments by 1 on every clock edge where we = 1; 32-bit, wraps 0xFFFFFFFF -> 0x00000000.
- Bubble: WB_input = 2'b00 or 2'b01 -> no write, no count, reads return stored values.

## Timing
- Reset (reset_n low, asynchronous): all 31 registers, write_count_output cleared to 0 immediately, without waiting for clock. While low: we = 0, read_data_1/2_output = 0, write_enable_output = 0; write_data_output still reflects the mux.
- Reset deasserted mid-cycle: first write can occur at the next rising edge.
- Write latency: 1 edge into storage; 0 cycles visible at read ports via bypass.
- Same cycle write and read of same register: read returns new value (bypass), not the old one.
- Back-to-back writes to same register: last edge wins; each counted.
- Write to register 0 with RegWrite = 1: no state change, counter unchanged.

## Structure
- Shared package: DATA_WIDTH, REG_ADDR_WIDTH, WB bit indices (WB_REGWRITE = 1, WB_MEMTOREG = 0).
- Sub-module: register_file (storage, async reset, two read ports with bypass, one write port); top handles mux, write enable qualification, and counter.

## Test plan
- Reset: hold reset_n low, drive WB_input = 2'b10, write_register_input = 5'd5 -> all reads 0, write_count_output = 0, no write on clock edges.
- ALU write-back: WB_input = 2'b10, alu_result_input = 0x5A5A5A5A, read_data_input = 0xA5A5A5A5, write_register_input = 5'h1F -> read port on 31 shows 0x5A5A5A5A same cycle (bypass) and after edge; count = 1.
- Load write-back: WB_input = 2'b11, read_data_input = 0xFFFFFFFF, write_register_input = 5'h0A -> reg 10 = 0xFFFFFFFF; write_data_output = 0xFFFFFFFF.
- No-write/zero: WB_input = 2'b01 to reg 0x0F, then 2'b10 to reg 0 with 0x12345678 -> reg 15 unchanged, reg 0 reads 0, count unchanged.
- Dual bypass: both read ports = 5'h0A while writing 0x87654321 to 10 -> both outputs 0x87654321 before edge.
- Reset mid-operation: after several writes, pulse reset_n low between edges -> registers and counter zero immediately; subsequent write counts from 1.
